// File: rtl/ntt_lane_serializer.sv
// ntt_lane_serializer: wide-beat to one-coefficient-per-cycle gearbox with polynomial first/last framing
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_first/in_data: wide beat of INPUT_PER_CYCLE lanes,
//   lane k at in_data[k*W +: W]; out_valid/out_ready/out_data/out_first/out_last: narrow coefficient stream;
//   frame_err: sticky framing error. Define BIT_REVERSE_EN to emit lanes in bit-reversed index order.
module ntt_lane_serializer #(
  parameter int DATA_WIDTH_PER_INPUT = 28,
  parameter int INPUT_PER_CYCLE = 64,
  parameter int N_COEFFS = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_first,
  input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [DATA_WIDTH_PER_INPUT-1:0] out_data,
  output logic out_first,
  output logic out_last,
  output logic frame_err
);
  localparam int W = DATA_WIDTH_PER_INPUT;
  localparam int P = INPUT_PER_CYCLE;
  localparam int B = N_COEFFS / INPUT_PER_CYCLE;
  localparam int LW = $clog2(P);
  localparam int BW = B > 1 ? $clog2(B) : 1;
  localparam logic [LW-1:0] LAST_L = LW'(P - 1);
  localparam logic [BW-1:0] LAST_B = BW'(B - 1);
  typedef enum logic {EMPTY, SHIFT} state_t;
  state_t state, state_nxt;
  logic [W-1:0] beat [P];
  logic [LW-1:0] lane, sel;
  logic [BW-1:0] cnt, cnt_inc, idx, beat_idx;
  logic beat_first, have, drain, in_hs, out_hs;
  assign drain = lane == LAST_L;
  assign out_hs = out_valid && out_ready;
  assign in_hs = in_valid && in_ready;
  assign cnt_inc = cnt == LAST_B ? '0 : cnt + 1'b1;
  // the first beat after reset always opens a new polynomial
  assign idx = (!have || in_first) ? '0 : cnt_inc;
  always_ff @(posedge clk)
    state <= rst ? EMPTY : state_nxt;
  always_comb
    state_nxt = in_hs ? SHIFT : (out_hs && drain) ? EMPTY : state;
  always_comb begin
`ifdef BIT_REVERSE_EN
    sel = {<<{lane}};
`else
    sel = lane;
`endif
    out_valid = !rst && state == SHIFT;
    in_ready = !rst && (state == EMPTY || (out_hs && drain));
    out_first = out_valid && lane == '0 && beat_first;
    out_last = out_valid && drain && beat_idx == LAST_B;
    out_data = out_valid ? beat[sel] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < P; i++) beat[i] <= '0;
      lane <= '0;
      cnt <= '0;
      beat_idx <= '0;
      beat_first <= 1'b0;
      have <= 1'b0;
      frame_err <= 1'b0;
    end else if (in_hs) begin
      for (int i = 0; i < P; i++) beat[i] <= in_data[i*W +: W];
      lane <= '0;
      cnt <= idx;
      beat_idx <= idx;
      beat_first <= in_first;
      have <= 1'b1;
      // in_first must coincide exactly with the counter wrapping back to beat 0
      if (have && (in_first != (cnt_inc == '0))) frame_err <= 1'b1;
    end else if (out_hs) begin
      lane <= lane + 1'b1;
    end
  end
endmodule

// File: tb/tb_ntt_lane_serializer.sv
// tb_ntt_lane_serializer: directed and randomized stimulus checked against a queue-based reference model
module tb_ntt_lane_serializer;
  localparam int W = 28;
  localparam int P = 4;
  localparam int N = 16;
  localparam int B = N / P;
  localparam int LW = 2;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_first, out_valid, out_ready, out_first, out_last, frame_err;
  logic [P*W-1:0] in_data;
  logic [W-1:0] out_data;
  int total = 0;
  int bad = 0;
  typedef struct {logic [W-1:0] d; logic f; logic l;} coef_t;
  coef_t q[$];
  bit have;
  int cnt;
  logic err;
  always #5 clk = ~clk;
  ntt_lane_serializer #(.DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(P), .N_COEFFS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .frame_err(frame_err)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int emit_lane(int k);
    int r = k;
`ifdef BIT_REVERSE_EN
    r = 0;
    for (int b = 0; b < LW; b++) if (((k >> b) & 1) == 1) r |= 1 << (LW - 1 - b);
`endif
    return r;
  endfunction
  function automatic void accept(bit f, logic [P*W-1:0] d);
    int nxt, idx;
    nxt = (cnt + 1) % B;
    if (have && ((f && nxt != 0) || (!f && nxt == 0))) err = 1'b1;
    idx = (!have || f) ? 0 : nxt;
    have = 1'b1;
    cnt = idx;
    for (int k = 0; k < P; k++)
      q.push_back('{d: d[emit_lane(k)*W +: W], f: f && k == 0, l: idx == B - 1 && k == P - 1});
  endfunction
  task automatic cyc(bit v, bit f, logic [P*W-1:0] d, bit r, output bit acc);
    bit rdy_e, out_e;
    in_valid = v;
    in_first = f;
    in_data = d;
    out_ready = r;
    #1;
    rdy_e = q.size() == 0 || (q.size() == 1 && r);
    out_e = q.size() > 0;
    chk("out_valid", 32'(out_valid), 32'(out_e));
    chk("in_ready", 32'(in_ready), 32'(rdy_e));
    chk("frame_err", 32'(frame_err), 32'(err));
    if (out_e) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_first", 32'(out_first), 32'(q[0].f));
      chk("out_last", 32'(out_last), 32'(q[0].l));
      if (r) void'(q.pop_front());
    end
    acc = v && rdy_e;
    if (acc) accept(f, d);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_first", 32'(out_first), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_frame_err", 32'(frame_err), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    rst = 1'b0;
    q.delete();
    have = 1'b0;
    cnt = 0;
    err = 1'b0;
  endtask
  function automatic logic [P*W-1:0] mkbeat(int bi, int mode);
    logic [P*W-1:0] d;
    for (int k = 0; k < P; k++) d[k*W +: W] = mode == 2 ? W'($urandom) : W'(bi * P + k);
    return d;
  endfunction
  task automatic stream(int nb, int mode, int restart_at);
    int bi, n;
    bit acc, v, r, f;
    logic [P*W-1:0] d;
    bi = 0;
    n = 0;
    d = mkbeat(0, mode);
    while ((bi < nb || q.size() > 0) && n < 600) begin
      v = bi < nb && (mode != 2 || $urandom_range(3) != 0);
      r = mode == 0 ? 1'b1 : mode == 1 ? (n % 4 == 0 || n % 4 == 3) : 1'($urandom_range(1));
      f = restart_at < 0 ? bi % B == 0 : (bi == 0 || bi == restart_at);
      cyc(v, f, d, r, acc);
      if (acc) begin
        bi++;
        d = mkbeat(bi, mode);
      end
      n++;
    end
    if (n >= 600) chk("timeout", 32'(1), 32'(0));
  endtask
  initial begin
    bit acc;
    logic [P*W-1:0] d;
    do_reset();
    d = {28'h13, 28'h12, 28'h11, 28'h10};
    cyc(1'b1, 1'b1, d, 1'b1, acc);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, '0, 1'b1, acc);
    do_reset();
    stream(4, 0, -1);
    do_reset();
    stream(4, 1, -1);
    do_reset();
    stream(6, 0, 2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, acc);
    chk("err_sticky", 32'(frame_err), 32'(1));
    do_reset();
    cyc(1'b1, 1'b1, d, 1'b1, acc);
    cyc(1'b0, 1'b0, '0, 1'b1, acc);
    cyc(1'b0, 1'b0, '0, 1'b1, acc);
    do_reset();
    cyc(1'b1, 1'b0, mkbeat(5, 0), 1'b1, acc);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0, 1'b1, acc);
    chk("post_rst_err", 32'(frame_err), 32'(0));
    do_reset();
    stream(12, 2, -1);
    stream(8, 1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
